sync_fifo_prog: RTL
===================

Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO for same-domain buffering; the single-clock counterpart to the team's dual-clock FIFO.
- Adds what that block lacks: occupancy count, runtime-programmable almost-full/almost-empty levels, sticky overflow/underflow error flags, synchronous flush.
- Sits between same-clock producer/consumer stages (e.g. packet staging ahead of a dual-clock crossing).

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 32, number of entries; power of two, >=2
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  push request
wr_data  input  WIDTH  push data
rd_en  input  1  pop request
rd_data  output  WIDTH  pop data
rd_valid  output  1  rd_data holds valid popped/head word
full  output  1  count==DEPTH
empty  output  1  count==0
almost_full  output  1  count>=af_level
almost_empty  output  1  count<=ae_level
count  output  ADDR_W+1  current occupancy 0..DEPTH
af_level  input  ADDR_W+1  almost-full threshold
ae_level  input  ADDR_W+1  almost-empty threshold
flush  input  1  synchronous clear of contents
clr_err  input  1  clears sticky error flags
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Clock/reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: pointers, count, rd_data, rd_valid, overflow, underflow = 0; empty=1, full=0. almost_empty/almost_full follow count against the levels (count=0). Memory contents are not reset.
- Pointers: wr_ptr/rd_ptr are ADDR_W+1-bit binary. The low ADDR_W bits address storage; the MSB is the wrap bit. They wrap naturally from DEPTH-1 to 0.
- Accept rules: push accepted iff wr_en && !full; pop accepted iff rd_en && !empty. Evaluation uses the pre-edge flags.
- Simultaneous push+pop, neither full nor empty: both accepted, count unchanged.
- Simultaneous push+pop while full: pop accepted, push dropped, overflow set.
- Simultaneous push+pop while empty: push accepted, pop rejected, underflow set. There is no bypass of the written word to rd_data.
- count: +1 on push-only, -1 on pop-only, otherwise held. full, empty and count update on the same edge as the accepted operation (registered, zero-cycle flag lag).
- almost_full/almost_empty: combinational compares on the registered count. af_level=0 gives almost_full constant 1; ae_level>=DEPTH gives almost_empty constant 1.
- Read timing (standard mode): accepted pop at edge N loads rd_data=mem[rd_ptr] at edge N. rd_valid=1 for the cycle after edge N, else 0. rd_data holds its last value when there is no pop.
- flush: synchronous, highest priority. Pointers and count go to 0, rd_valid goes to 0. wr_en/rd_en in the same cycle are ignored and set no error flags. overflow/underflow are unchanged.
- Error flags: overflow/underflow are sticky until clr_err. If clr_err coincides with a new error event, the flag stays 1 (set wins).
- Reset mid-operation: all state returns to reset values immediately, and any in-flight rd_valid is lost.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - rd_data = mem[rd_ptr] combinationally.
  - rd_valid = !empty (flush still forces rd_valid=0).
  - rd_en acts as a pop acknowledge; the next head appears in the same cycle after the edge.
  - Read latency is zero.
- Undefined: standard registered-read behaviour as above.
- All other behaviour is identical in both modes.

Decomposition:
- Shared package fifo_pkg: ADDR_W/count-width derivation helper and the flag bit-position constants (overflow/underflow order), reused by the dual-clock FIFO's status path.
- One sub-module, sfifo_ram: DEPTH x WIDTH flop array, one write port (clk) and one combinational read port. The top holds pointers, count, flags and the output register.

Test Plan:
- Reset, then 32 pushes of 0x00..0x1F -> count=32, full=1 after 32nd edge; 32 pops return 0x00..0x1F in order, empty=1 after last; standard mode rd_valid 1 cycle after each pop.
- af_level=28, ae_level=3 -> almost_full rises on edge making count=28 and falls at 27; almost_empty=1 for count<=3.
- Full FIFO, wr_en=rd_en=1 one cycle -> count stays 32 minus 1 = 31, overflow=1, pushed word absent from later read stream; clr_err -> overflow=0.
- Empty FIFO, wr_en=rd_en=1 with 0xA5 -> count=1, underflow=1, next pop returns 0xA5.
- Fill 10, pointers wrapped past index 31 (push/pop 40 total), assert flush with wr_en=1 -> count=0, empty=1, no overflow; rst_n pulse mid-burst -> all outputs at reset values same cycle.
- SYNC_FIFO_FWFT_EN defined: push 0x11,0x22 -> rd_valid=1, rd_data=0x11 with no rd_en; pulse rd_en -> rd_data=0x22 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: address/count width helpers and error-flag bit positions.
// Used by the single-clock FIFO and the dual-clock FIFO status path.
package fifo_pkg;

  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_UDF_BIT = 1;
  localparam int unsigned ERR_W       = 2;

  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned fifo_count_w(input int unsigned depth);
    return fifo_addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// DEPTH x WIDTH flop-array storage: one clocked write port, one combinational read port.
module sfifo_ram
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 32,
  localparam int unsigned ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; only valid entries, tracked by the pointers, are ever read out.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 32,
  localparam int unsigned ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  input  logic [ADDR_W:0]   af_level,
  input  logic [ADDR_W:0]   ae_level,
  input  logic              flush,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_evt, w_err_nxt;
  logic [WIDTH-1:0] w_head;
  logic             w_push, w_pop;

  assign full         = (r_count == CNT_W'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= af_level);
  assign almost_empty = (r_count <= ae_level);
  assign count        = r_count;
  assign overflow     = r_err[ERR_OVF_BIT];
  assign underflow    = r_err[ERR_UDF_BIT];

  // Flush swallows both requests, including their error side effects.
  assign w_push = wr_en && !full  && !flush;
  assign w_pop  = rd_en && !empty && !flush;

  assign w_err_evt[ERR_OVF_BIT] = wr_en && full  && !flush;
  assign w_err_evt[ERR_UDF_BIT] = rd_en && empty && !flush;

  // NOTE: default assigned first so every path drives w_err_nxt and no latch is inferred.
  always_comb begin
    w_err_nxt = r_err;
    if (clr_err) w_err_nxt = '0;
    w_err_nxt = w_err_nxt | w_err_evt;
  end

  sfifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_head)
  );

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= '0;
    end else begin
      r_err <= w_err_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + CNT_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + CNT_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = w_head;
  assign rd_valid = !empty && !flush;
`else
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= w_head;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

endmodule
